rtc_display_driver: RTL and testbench

Consumer end of the real-time-clock time interface. Takes the binary `hour_counter`/`min_counter`/`sec_counter` fields plus `clk_1Hz` and `mode` from the RTC and drives a multiplexed six-digit common-anode seven-segment display as HH.MM.SS. The block snapshots the time once per display frame and converts it to BCD with a sequential subtract-by-ten engine. It blinks the editable fields while the RTC is in set mode.

---
 rtl/rtc_display_driver.sv | 238 +++++++++++++++++++++++
 tb/tb_rtc_display_driver.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/rtc_display_driver.sv
// rtc_display_driver: six-digit multiplexed common-anode 7-segment driver for an RTC.
// The time is snapshotted once per frame and converted to BCD by a subtract-by-ten engine.
// Converted digits are double buffered, so the display only changes at a frame wrap.
// The hour and minute fields blink while the RTC is in set mode.
//
// Ports:
//   clk_50MHz     system clock, rising edge
//   reset         synchronous active-high reset
//   hour_counter  binary hours   (valid 0..23)
//   min_counter   binary minutes (valid 0..59)
//   sec_counter   binary seconds (valid 0..59)
//   clk_1Hz       RTC 1 Hz square wave, used as a level
//   mode          0 = run, 1 = set (blink)
//   seg_n         active-low segments, bit0 = a .. bit6 = g
//   dp_n          active-low decimal point
//   digit_en_n    active-low digit enables, bit0 = hour tens .. bit5 = sec ones
module rtc_display_driver #(
    parameter int unsigned SCAN_DIV = 50000
) (
    input  logic       clk_50MHz,
    input  logic       reset,
    input  logic [5:0] hour_counter,
    input  logic [5:0] min_counter,
    input  logic [5:0] sec_counter,
    input  logic       clk_1Hz,
    input  logic       mode,
    output logic [6:0] seg_n,
    output logic       dp_n,
    output logic [5:0] digit_en_n
);

    localparam int unsigned PRE_W  = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int unsigned IDX_W  = 3;
    localparam int unsigned DIG_W  = 4;
    localparam int unsigned VAL_W  = 6;
    localparam int unsigned NUM_DIG = 6;

    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(SCAN_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIG - 1);

    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_DASH  = 7'b0111111;

    typedef enum logic [1:0] {
        IDLE,
        CONV_H,
        CONV_M,
        CONV_S
    } conv_state_t;

    conv_state_t state, state_next_c;

    logic [PRE_W-1:0] pre;
    logic [IDX_W-1:0] idx;
    logic             snap_pending;

    logic [VAL_W-1:0] work;
    logic [DIG_W-1:0] tens;
    logic [VAL_W-1:0] min_snap;
    logic [VAL_W-1:0] sec_snap;

    logic [NUM_DIG-1:0][DIG_W-1:0] pend_bcd;
    logic [NUM_DIG-1:0][DIG_W-1:0] disp_bcd;
    logic [2:0]                    pend_inv;
    logic [2:0]                    disp_inv;

    logic slot_end_c;
    logic frame_wrap_c;
    logic work_ge10_c;

    logic [DIG_W-1:0] cur_digit_c;
    logic             cur_inv_c;
    logic [6:0]       seg_code_c;
    logic [6:0]       seg_next_c;
    logic             dp_next_c;
    logic [5:0]       en_next_c;

    assign slot_end_c   = (pre == PRE_LAST);
    assign frame_wrap_c = slot_end_c && (idx == IDX_LAST);
    assign work_ge10_c  = (work >= VAL_W'(10));

    // Converter state register; a snapshot always restarts at the hour field.
    always_ff @(posedge clk_50MHz) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next_c;
        end
    end

    // Converter next state: leave a field once its remainder drops below ten.
    always_comb begin
        state_next_c = state;
        if (snap_pending) begin
            state_next_c = CONV_H;
        end else begin
            case (state)
                CONV_H:  if (!work_ge10_c) state_next_c = CONV_M;
                CONV_M:  if (!work_ge10_c) state_next_c = CONV_S;
                CONV_S:  if (!work_ge10_c) state_next_c = IDLE;
                default: state_next_c = IDLE;
            endcase
        end
    end

    // Scan timing, snapshot, BCD datapath and double buffer.
    always_ff @(posedge clk_50MHz) begin
        if (reset) begin
            pre          <= '0;
            idx          <= '0;
            snap_pending <= 1'b1;
            work         <= '0;
            tens         <= '0;
            min_snap     <= '0;
            sec_snap     <= '0;
            pend_bcd     <= '0;
            disp_bcd     <= '0;
            pend_inv     <= '0;
            disp_inv     <= '0;
        end else begin
            pre <= slot_end_c ? '0 : pre + PRE_W'(1);
            if (slot_end_c) begin
                idx <= (idx == IDX_LAST) ? '0 : idx + IDX_W'(1);
            end

            // Commit whatever the converter left pending; the display is frozen within a frame.
            if (frame_wrap_c) begin
                disp_bcd <= pend_bcd;
                disp_inv <= pend_inv;
            end

            snap_pending <= frame_wrap_c;

            if (snap_pending) begin
                work     <= hour_counter;
                tens     <= '0;
                min_snap <= min_counter;
                sec_snap <= sec_counter;
                pend_inv <= {sec_counter > VAL_W'(59),
                             min_counter > VAL_W'(59),
                             hour_counter > VAL_W'(23)};
            end else if (state != IDLE) begin
                if (work_ge10_c) begin
                    work <= work - VAL_W'(10);
                    tens <= tens + DIG_W'(1);
                end else begin
                    // Remainder is the ones digit; load the next field.
                    tens <= '0;
                    case (state)
                        CONV_H: begin
                            pend_bcd[0] <= tens;
                            pend_bcd[1] <= work[DIG_W-1:0];
                            work        <= min_snap;
                        end
                        CONV_M: begin
                            pend_bcd[2] <= tens;
                            pend_bcd[3] <= work[DIG_W-1:0];
                            work        <= sec_snap;
                        end
                        default: begin
                            pend_bcd[4] <= tens;
                            pend_bcd[5] <= work[DIG_W-1:0];
                        end
                    endcase
                end
            end
        end
    end

    // Select the digit and field-invalid flag for the current slot.
    always_comb begin
        cur_digit_c = '0;
        cur_inv_c   = 1'b0;
        case (idx)
            3'd0: begin cur_digit_c = disp_bcd[0]; cur_inv_c = disp_inv[0]; end
            3'd1: begin cur_digit_c = disp_bcd[1]; cur_inv_c = disp_inv[0]; end
            3'd2: begin cur_digit_c = disp_bcd[2]; cur_inv_c = disp_inv[1]; end
            3'd3: begin cur_digit_c = disp_bcd[3]; cur_inv_c = disp_inv[1]; end
            3'd4: begin cur_digit_c = disp_bcd[4]; cur_inv_c = disp_inv[2]; end
            3'd5: begin cur_digit_c = disp_bcd[5]; cur_inv_c = disp_inv[2]; end
            default: ;
        endcase
    end

    // Active-low segment decode, g..a.
    always_comb begin
        seg_code_c = SEG_DASH;
        case (cur_digit_c)
            4'd0: seg_code_c = 7'b1000000;
            4'd1: seg_code_c = 7'b1111001;
            4'd2: seg_code_c = 7'b0100100;
            4'd3: seg_code_c = 7'b0110000;
            4'd4: seg_code_c = 7'b0011001;
            4'd5: seg_code_c = 7'b0010010;
            4'd6: seg_code_c = 7'b0000010;
            4'd7: seg_code_c = 7'b1111000;
            4'd8: seg_code_c = 7'b0000000;
            4'd9: seg_code_c = 7'b0010000;
            default: ;
        endcase
    end

    // Next output values; the first cycle of each slot is blanked to avoid ghosting.
    always_comb begin
        seg_next_c = cur_inv_c ? SEG_DASH : seg_code_c;
        dp_next_c  = 1'b1;
        en_next_c  = ~(6'(1) << idx);

        // Blink hours and minutes in set mode during the low half of the second.
        if (mode && !clk_1Hz && (idx < IDX_W'(4))) begin
            seg_next_c = SEG_BLANK;
        end

        if (((idx == IDX_W'(1)) || (idx == IDX_W'(3))) && (mode || clk_1Hz)) begin
            dp_next_c = 1'b0;
        end

        if (pre == '0) begin
            seg_next_c = SEG_BLANK;
            dp_next_c  = 1'b1;
            en_next_c  = '1;
        end
    end

    // Registered outputs.
    always_ff @(posedge clk_50MHz) begin
        if (reset) begin
            seg_n      <= SEG_BLANK;
            dp_n       <= 1'b1;
            digit_en_n <= '1;
        end else begin
            seg_n      <= seg_next_c;
            dp_n       <= dp_next_c;
            digit_en_n <= en_next_c;
        end
    end

endmodule

// File: tb/tb_rtc_display_driver.sv
// Testbench for rtc_display_driver: directed scenarios plus randomized inputs,
// checked every cycle against a frame-level model of the display.
module tb_rtc_display_driver;

    localparam int unsigned SCAN_DIV = 20;
    localparam int unsigned FRAME    = 6 * SCAN_DIV;
    localparam logic [13:0] ALL_OFF  = 14'h3fff;

    logic       clk_50MHz = 1'b0;
    logic       reset = 1'b1;
    logic [5:0] hour_counter = 6'd12;
    logic [5:0] min_counter  = 6'd34;
    logic [5:0] sec_counter  = 6'd56;
    logic       clk_1Hz = 1'b1;
    logic       mode = 1'b0;
    logic [6:0] seg_n;
    logic       dp_n;
    logic [5:0] digit_en_n;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int pend_h = 0, pend_m = 0, pend_s = 0;
    int disp_h = 0, disp_m = 0, disp_s = 0;

    rtc_display_driver #(.SCAN_DIV(SCAN_DIV)) dut (
        .clk_50MHz    (clk_50MHz),
        .reset        (reset),
        .hour_counter (hour_counter),
        .min_counter  (min_counter),
        .sec_counter  (sec_counter),
        .clk_1Hz      (clk_1Hz),
        .mode         (mode),
        .seg_n        (seg_n),
        .dp_n         (dp_n),
        .digit_en_n   (digit_en_n)
    );

    always #5 clk_50MHz = ~clk_50MHz;

    // Compare the packed {digit_en_n, dp_n, seg_n} word.
    task automatic check(input string tag, input logic [13:0] got, input logic [13:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s cyc=%0d: got en=%b dp=%b seg=%b, want en=%b dp=%b seg=%b",
                     tag, cyc, got[13:8], got[7], got[6:0], exp[13:8], exp[7], exp[6:0]);
        end
    endtask

    function automatic logic [6:0] digit_seg(input int d);
        case (d)
            0: return 7'b1000000;
            1: return 7'b1111001;
            2: return 7'b0100100;
            3: return 7'b0110000;
            4: return 7'b0011001;
            5: return 7'b0010010;
            6: return 7'b0000010;
            7: return 7'b1111000;
            8: return 7'b0000000;
            default: return 7'b0010000;
        endcase
    endfunction

    // Expected output word for one slot cycle of a frame showing h:m:s.
    function automatic logic [13:0] model_out(input int pre, input int slot,
                                              input int h, input int m, input int s,
                                              input logic md, input logic c1);
        int v, lim, d;
        logic [6:0] seg;
        logic       dp;
        logic [5:0] en;
        if (pre == 0) return ALL_OFF;
        v   = (slot < 2) ? h : ((slot < 4) ? m : s);
        lim = (slot < 2) ? 23 : 59;
        d   = (slot % 2 == 0) ? v / 10 : v % 10;
        seg = (v > lim) ? 7'b0111111 : digit_seg(d);
        if (md && !c1 && slot < 4) seg = 7'b1111111;
        dp  = ((slot == 1 || slot == 3) && (md || c1)) ? 1'b0 : 1'b1;
        en  = 6'h3f;
        en[slot] = 1'b0;
        return {en, dp, seg};
    endfunction

    task automatic set_time(input int h, input int m, input int s);
        hour_counter = 6'(h);
        min_counter  = 6'(m);
        sec_counter  = 6'(s);
    endtask

    // One clock cycle: update the frame model, then compare the registered outputs.
    task automatic step(input string tag);
        logic [13:0] exp;
        if (cyc % FRAME == 0) begin
            disp_h = pend_h; disp_m = pend_m; disp_s = pend_s;
            pend_h = int'(hour_counter); pend_m = int'(min_counter); pend_s = int'(sec_counter);
        end
        exp = model_out(cyc % SCAN_DIV, (cyc / SCAN_DIV) % 6, disp_h, disp_m, disp_s, mode, clk_1Hz);
        @(posedge clk_50MHz);
        #1;
        check(tag, {digit_en_n, dp_n, seg_n}, exp);
        cyc++;
    endtask

    task automatic run(input string tag, input int k);
        for (int i = 0; i < k; i++) step(tag);
    endtask

    task automatic do_reset(input int k);
        reset = 1'b1;
        for (int i = 0; i < k; i++) begin
            @(posedge clk_50MHz);
            #1;
            check("reset", {digit_en_n, dp_n, seg_n}, ALL_OFF);
        end
        reset = 1'b0;
        cyc = 0;
        pend_h = 0; pend_m = 0; pend_s = 0;
        disp_h = 0; disp_m = 0; disp_s = 0;
    endtask

    initial begin
        // Reset, then 12:34:56 with a change to 23:59:59 during slot 2 of frame 1.
        do_reset(3);
        run("decode", FRAME + 2 * SCAN_DIV + 5);
        set_time(23, 59, 59);
        run("midframe", 3 * FRAME - (FRAME + 2 * SCAN_DIV + 5));

        // Out-of-range fields show dashes.
        set_time(30, 45, 60);
        run("invalid", 2 * FRAME);

        // Set-mode blink and separator behaviour.
        set_time(9, 7, 3);
        run("preblink", FRAME);
        mode = 1'b1; clk_1Hz = 1'b0;
        run("blink_lo", FRAME);
        clk_1Hz = 1'b1;
        run("blink_hi", FRAME);
        mode = 1'b0; clk_1Hz = 1'b0;
        run("run_lo", FRAME);
        clk_1Hz = 1'b1;

        // Reset two cycles after a snapshot of 23:59:59.
        set_time(23, 59, 59);
        do_reset(2);
        run("snap", 2);
        reset = 1'b1;
        set_time(7, 8, 9);
        do_reset(2);
        run("rst_conv", 2 * FRAME);

        // Randomized inputs, mode and 1 Hz level.
        for (int i = 0; i < 16 * FRAME; i++) begin
            if ($urandom_range(0, 49) == 0)
                set_time(int'($urandom_range(0, 31)), int'($urandom_range(0, 63)),
                         int'($urandom_range(0, 63)));
            if ($urandom_range(0, 29) == 0) mode = ~mode;
            if ($urandom_range(0, 9) == 0) clk_1Hz = ~clk_1Hz;
            step("random");
        end

        // Random-point reset followed by two frames.
        run("prerst", int'($urandom_range(1, FRAME - 1)));
        set_time(int'($urandom_range(0, 23)), int'($urandom_range(0, 59)),
                 int'($urandom_range(0, 59)));
        do_reset(1);
        run("postrst", 2 * FRAME);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
